// File: rtl/tx_pkg.sv
// Shared definitions for the parametrised serial transmitter: FSM states,
// parity modes and the frame-length helper.
package tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } tx_state_e;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   function automatic int unsigned frame_len(input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits,
                                             input int unsigned clk_div);
      return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * clk_div;
   endfunction

endpackage

// File: rtl/tx_baud_gen.sv
// Bit-period timer: counts CLK_DIV clocks per bit and strobes bit_tick_o in the
// last cycle of each bit; restart_i holds the count at zero.
module tx_baud_gen #(
   parameter int unsigned CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart_i,
   output logic bit_tick_o
);

   localparam int unsigned CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign bit_tick_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart_i || bit_tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tx_uart_param.sv
// Parametrised LSB-first serial transmitter with a one-entry holding buffer,
// edge-qualified start, overflow pulse and frame-done pulse.
module tx_uart_param
   import tx_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned CLK_DIV   = 16,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_pi,
   output logic                 tx_so,
   output logic                 tx_busy,
   output logic                 tx_ready,
   output logic                 tx_done,
   output logic                 tx_ovf
);

   if (DATA_BITS < 5 || DATA_BITS > 9 || CLK_DIV < 2 || CLK_DIV > 65535 ||
       PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
      $fatal(1, "tx_uart_param: illegal parameter value");
   end

   localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
   localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

   tx_state_e            state_q, state_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic [DATA_BITS-1:0] buf_q, buf_d;
   logic                 buf_full_q, buf_full_d;
   logic                 par_q, par_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic                 so_q, so_d;
   logic                 ovf_q, ovf_d;
   logic                 start_q;
   logic                 arm_q;
   logic                 start_edge;
   logic                 load_sh;
   logic                 done;
   logic                 bit_tick;

   tx_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
      .clk        (clk),
      .rst_n      (rst_n),
      .restart_i  (state_q == IDLE),
      .bit_tick_o (bit_tick)
   );

   // arm_q masks the first cycle after reset so a start level held through reset is not an edge
   assign start_edge = tx_start & ~start_q & arm_q;

   always_comb begin
      state_d    = state_q;
      sh_d       = sh_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      par_d      = par_q;
      bit_d      = bit_q;
      so_d       = so_q;
      load_sh    = 1'b0;
      done       = 1'b0;
      ovf_d      = start_edge & buf_full_q;

      case (state_q)
         IDLE: begin
            if (buf_full_q) load_sh = 1'b1;
         end
         START: begin
            if (bit_tick) begin
               state_d = DATA;
               bit_d   = '0;
               so_d    = sh_q[0];
            end
         end
         DATA: begin
            if (bit_tick) begin
               if (bit_q == LAST_DATA) begin
                  bit_d = '0;
                  if (PARITY != PAR_NONE) begin
                     state_d = PAR;
                     so_d    = par_q;
                  end else begin
                     state_d = STOP;
                     so_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
                  sh_d  = sh_q >> 1;
                  so_d  = sh_q[1];
               end
            end
         end
         PAR: begin
            if (bit_tick) begin
               state_d = STOP;
               bit_d   = '0;
               so_d    = 1'b1;
            end
         end
         STOP: begin
            if (bit_tick) begin
               if (bit_q == LAST_STOP) begin
                  done = 1'b1;
                  if (buf_full_q) begin
                     load_sh = 1'b1;
                  end else begin
                     state_d = IDLE;
                     so_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load_sh) begin
         state_d    = START;
         sh_d       = buf_q;
         par_d      = (PARITY == PAR_ODD) ? ~(^buf_q) : ^buf_q;
         so_d       = 1'b0;
         buf_full_d = 1'b0;
      end else if (start_edge && !buf_full_q) begin
         buf_d      = tx_pi;
         buf_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sh_q       <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         par_q      <= 1'b0;
         bit_q      <= '0;
         so_q       <= 1'b1;
         ovf_q      <= 1'b0;
         start_q    <= 1'b0;
         arm_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         par_q      <= par_d;
         bit_q      <= bit_d;
         so_q       <= so_d;
         ovf_q      <= ovf_d;
         start_q    <= tx_start;
         arm_q      <= 1'b1;
      end
   end

   assign tx_so    = so_q;
   assign tx_busy  = (state_q != IDLE);
   assign tx_ready = ~buf_full_q;
   assign tx_done  = done;
   assign tx_ovf   = ovf_q;

endmodule

// File: tb/tb_tx_uart_param.sv
// Directed bench for tx_uart_param: four configurations side by side, a
// negedge monitor logging each busy cycle, and immediate-assertion checks.
module tb_tx_uart_param;
   import tx_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mon_clr;
   logic       st   [4];
   logic       so   [4];
   logic       busy [4];
   logic       rdy  [4];
   logic       done [4];
   logic       ovf  [4];
   logic [7:0] pi0, pi1, pi2;
   logic [4:0] pi3;

   int checks   = 0;
   int failures = 0;

   logic        lg     [4][256];
   int unsigned ln     [4];
   int unsigned done_n [4];
   int unsigned ovf_n  [4];
   int unsigned falls  [4];
   int unsigned d1     [4];
   int unsigned d2     [4];
   logic        bprev  [4];

   always #5 clk = ~clk;

   tx_uart_param #(.DATA_BITS(8), .CLK_DIV(4), .PARITY(PAR_NONE), .STOP_BITS(1)) u_none (
      .clk(clk), .rst_n(rst_n), .tx_start(st[0]), .tx_pi(pi0), .tx_so(so[0]),
      .tx_busy(busy[0]), .tx_ready(rdy[0]), .tx_done(done[0]), .tx_ovf(ovf[0]));

   tx_uart_param #(.DATA_BITS(8), .CLK_DIV(4), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_even (
      .clk(clk), .rst_n(rst_n), .tx_start(st[1]), .tx_pi(pi1), .tx_so(so[1]),
      .tx_busy(busy[1]), .tx_ready(rdy[1]), .tx_done(done[1]), .tx_ovf(ovf[1]));

   tx_uart_param #(.DATA_BITS(8), .CLK_DIV(4), .PARITY(PAR_ODD), .STOP_BITS(1)) u_odd (
      .clk(clk), .rst_n(rst_n), .tx_start(st[2]), .tx_pi(pi2), .tx_so(so[2]),
      .tx_busy(busy[2]), .tx_ready(rdy[2]), .tx_done(done[2]), .tx_ovf(ovf[2]));

   tx_uart_param #(.DATA_BITS(5), .CLK_DIV(2), .PARITY(PAR_NONE), .STOP_BITS(2)) u_five (
      .clk(clk), .rst_n(rst_n), .tx_start(st[3]), .tx_pi(pi3), .tx_so(so[3]),
      .tx_busy(busy[3]), .tx_ready(rdy[3]), .tx_done(done[3]), .tx_ovf(ovf[3]));

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (mon_clr) begin
            ln[i]     <= 0;
            done_n[i] <= 0;
            ovf_n[i]  <= 0;
            falls[i]  <= 0;
            d1[i]     <= 0;
            d2[i]     <= 0;
            bprev[i]  <= 1'b0;
         end else begin
            bprev[i] <= busy[i];
            if (bprev[i] && !busy[i]) falls[i] <= falls[i] + 1;
            if (busy[i]) begin
               if (ln[i] < 256) lg[i][ln[i]] <= so[i];
               ln[i] <= ln[i] + 1;
            end
            if (done[i]) begin
               done_n[i] <= done_n[i] + 1;
               if (done_n[i] == 0) d1[i] <= ln[i];
               else                d2[i] <= ln[i];
            end
            if (ovf[i]) ovf_n[i] <= ovf_n[i] + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every logged busy cycle against the expected serial bit it belongs to.
   task automatic chk_frame(input int i, input logic [63:0] bits, input int nb,
                            input int div, input string tag);
      int unsigned bad = 0;
      for (int c = 0; c < nb * div; c++) begin
         if (lg[i][c] !== bits[c / div]) bad++;
      end
      check({tag, "_len"}, 64'(ln[i]), 64'(nb * div));
      check({tag, "_badbits"}, 64'(bad), 64'd0);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      cyc(1);
      mon_clr = 1'b0;
   endtask

   initial begin
      logic [63:0] e;
      rst_n   = 1'b0;
      mon_clr = 1'b1;
      for (int i = 0; i < 4; i++) st[i] = 1'b0;
      pi0 = '0; pi1 = '0; pi2 = '0; pi3 = '0;

      #12;
      check("rst_so",    64'(so[0]),   64'd1);
      check("rst_busy",  64'(busy[0]), 64'd0);
      check("rst_ready", 64'(rdy[0]),  64'd1);
      check("rst_done",  64'(done[0]), 64'd0);
      check("rst_ovf",   64'(ovf[0]),  64'd0);

      cyc(1);
      rst_n   = 1'b1;
      mon_clr = 1'b0;
      cyc(2);

      // Single frames on all four configurations, start held high for 5 cycles
      for (int i = 0; i < 4; i++) st[i] = 1'b1;
      pi0 = 8'hAC; pi1 = 8'hDC; pi2 = 8'hDC; pi3 = 5'h15;
      cyc(1);
      check("lat_ready_low", 64'(rdy[0]),  64'd0);
      check("lat_busy_low",  64'(busy[0]), 64'd0);
      check("lat_so_idle",   64'(so[0]),   64'd1);
      cyc(1);
      check("lat_busy_high", 64'(busy[0]), 64'd1);
      check("lat_so_start",  64'(so[0]),   64'd0);
      check("lat_ready_bk",  64'(rdy[0]),  64'd1);
      pi0 = 8'hFF;
      cyc(3);
      for (int i = 0; i < 4; i++) st[i] = 1'b0;
      cyc(50);

      e = 64'({1'b1, 8'hAC, 1'b0});
      chk_frame(0, e, 10, 4, "f_none");
      check("f_none_done",  64'(done_n[0]), 64'd1);
      check("f_none_dpos",  64'(d1[0]),     64'd39);
      check("f_none_ovf",   64'(ovf_n[0]),  64'd0);
      check("f_none_falls", 64'(falls[0]),  64'd1);

      e = 64'({1'b1, 1'b1, 8'hDC, 1'b0});
      chk_frame(1, e, 11, 4, "f_even");
      check("f_even_pkglen", 64'(ln[1]), 64'(frame_len(8, PAR_EVEN, 1, 4)));
      check("f_even_dpos",   64'(d1[1]), 64'd43);

      e = 64'({1'b1, 1'b0, 8'hDC, 1'b0});
      chk_frame(2, e, 11, 4, "f_odd");

      e = 64'({2'b11, 5'h15, 1'b0});
      chk_frame(3, e, 8, 2, "f_five");
      check("f_five_done", 64'(done_n[3]), 64'd1);
      check("f_five_dpos", 64'(d1[3]),     64'd15);

      // Back-to-back: second edge three cycles after the first
      clear_mon();
      pi0 = 8'hAC; st[0] = 1'b1;
      cyc(1);
      check("b2b_ready0", 64'(rdy[0]), 64'd0);
      st[0] = 1'b0;
      cyc(1);
      check("b2b_ready1", 64'(rdy[0]), 64'd1);
      cyc(1);
      pi0 = 8'hDC; st[0] = 1'b1;
      cyc(1);
      check("b2b_ready2", 64'(rdy[0]), 64'd0);
      st[0] = 1'b0;
      cyc(100);
      e = 64'({1'b1, 8'hDC, 1'b0, 1'b1, 8'hAC, 1'b0});
      chk_frame(0, e, 20, 4, "b2b");
      check("b2b_done",  64'(done_n[0]), 64'd2);
      check("b2b_d1",    64'(d1[0]),     64'd39);
      check("b2b_d2",    64'(d2[0]),     64'd79);
      check("b2b_falls", 64'(falls[0]),  64'd1);
      check("b2b_ovf",   64'(ovf_n[0]),  64'd0);

      // Overflow: third edge while the buffer still holds the second word
      clear_mon();
      pi0 = 8'hAC; st[0] = 1'b1;
      cyc(1);
      st[0] = 1'b0;
      cyc(4);
      pi0 = 8'hDC; st[0] = 1'b1;
      cyc(1);
      st[0] = 1'b0;
      cyc(4);
      pi0 = 8'h55; st[0] = 1'b1;
      cyc(1);
      check("ovf_pulse", 64'(ovf[0]), 64'd1);
      check("ovf_ready", 64'(rdy[0]), 64'd0);
      st[0] = 1'b0;
      cyc(1);
      check("ovf_clear", 64'(ovf[0]), 64'd0);
      cyc(100);
      e = 64'({1'b1, 8'hDC, 1'b0, 1'b1, 8'hAC, 1'b0});
      chk_frame(0, e, 20, 4, "ovf");
      check("ovf_count", 64'(ovf_n[0]),  64'd1);
      check("ovf_done",  64'(done_n[0]), 64'd2);

      // Asynchronous reset during data bit 3 with the buffer full
      clear_mon();
      pi0 = 8'h00; st[0] = 1'b1;
      cyc(1);
      st[0] = 1'b0;
      cyc(4);
      pi0 = 8'hFF; st[0] = 1'b1;
      cyc(13);
      #2;
      check("mid_so",    64'(so[0]),   64'd0);
      check("mid_busy",  64'(busy[0]), 64'd1);
      check("mid_ready", 64'(rdy[0]),  64'd0);
      rst_n = 1'b0;
      #1;
      check("arst_so",    64'(so[0]),   64'd1);
      check("arst_busy",  64'(busy[0]), 64'd0);
      check("arst_ready", 64'(rdy[0]),  64'd1);
      cyc(2);
      rst_n = 1'b1;
      clear_mon();
      cyc(5);
      check("held_busy",  64'(busy[0]), 64'd0);
      check("held_ready", 64'(rdy[0]),  64'd1);
      st[0] = 1'b0;
      cyc(1);
      pi0 = 8'h0F; st[0] = 1'b1;
      cyc(1);
      st[0] = 1'b0;
      cyc(50);
      e = 64'({1'b1, 8'h0F, 1'b0});
      chk_frame(0, e, 10, 4, "post_rst");
      check("post_rst_done", 64'(done_n[0]), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
